// File: rtl/iob_eth_wb_mem_pkg.sv
// Shared definitions for the Wishbone slave memory: bus codes, FSM encoding, widths.
// No logic lives here; the wrap-mask helper is a pure function.
// Imported by the top and the RAM so both agree on data and select widths.
package iob_eth_wb_mem_pkg;

  localparam int DATA_W = 32;
  localparam int SEL_W  = DATA_W / 8;
  localparam int WAIT_W = 4;

  // Wishbone cycle type identifiers
  typedef enum logic [2:0] {
    CTI_CLASSIC = 3'b000,
    CTI_INCR    = 3'b010,
    CTI_EOB     = 3'b111
  } cti_e;

  // Wishbone burst type extensions
  typedef enum logic [1:0] {
    BTE_LINEAR = 2'b00,
    BTE_WRAP4  = 2'b01,
    BTE_WRAP8  = 2'b10,
    BTE_WRAP16 = 2'b11
  } bte_e;

  // Bus FSM states; an error response is an ACK-state cycle flagged by err_q
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_ACK   = 2'd2,
    ST_BURST = 2'd3
  } state_e;

  // Bits of the word address that advance during a burst; the rest stay fixed.
  // Linear bursts advance every bit, so they roll over the top of the RAM.
  function automatic logic [31:0] bte_mask(input logic [1:0] bte);
    logic [31:0] m;
    m = '1;
    case (bte_e'(bte))
      BTE_WRAP4:  m = 32'd3;
      BTE_WRAP8:  m = 32'd7;
      BTE_WRAP16: m = 32'd15;
      default:    m = '1;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/iob_eth_wb_mem_ram.sv
// Single-port word RAM with per-byte write enables.
// Latency: write lands on the clock edge, read is combinational from the address.
// No flow control and no reset: contents survive a bus reset.
module iob_eth_wb_mem_ram
  import iob_eth_wb_mem_pkg::*;
#(
  parameter int ADDR_W = 12
) (
  input  logic              clk_i,
  input  logic [SEL_W-1:0]  be_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [0:(1<<ADDR_W)-1];

  // Byte-lane writes; lanes with a clear enable keep their old contents
  always_ff @(posedge clk_i) begin
    for (int b = 0; b < SEL_W; b++) begin
      if (be_i[b]) begin
        mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
      end
    end
  end

  assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/iob_eth_wb_mem.sv
// Wishbone B4 slave backed by an internal RAM, serving the Ethernet MAC master port.
// Latency: WAIT_CYCLES wait states before the first ack, then one beat per cycle in bursts.
// Backpressure: a beat is only acked while cyc&stb are high; dropping either ends the cycle.
module iob_eth_wb_mem
  import iob_eth_wb_mem_pkg::*;
#(
  parameter int MEM_ADDR_W  = 32,
  parameter int RAM_ADDR_W  = 12,
  parameter int WAIT_CYCLES = 1
) (
  input  logic                  clk_i,
  input  logic                  arst_n_i,
  input  logic [MEM_ADDR_W-1:0] wb_adr_i,
  input  logic [SEL_W-1:0]      wb_sel_i,
  input  logic                  wb_we_i,
  input  logic                  wb_cyc_i,
  input  logic                  wb_stb_i,
  input  logic [DATA_W-1:0]     wb_dat_i,
  input  logic [2:0]            wb_cti_i,
  input  logic [1:0]            wb_bte_i,
  output logic [DATA_W-1:0]     wb_dat_o,
  output logic                  wb_ack_o,
  output logic                  wb_err_o,
  output logic [15:0]           beat_cnt_o
);

  state_e                state_q;
  logic                  ack_q;
  logic                  err_q;
  logic [WAIT_W-1:0]     wait_cnt_q;
  logic [RAM_ADDR_W-1:0] addr_q;
  logic [1:0]            bte_q;
  logic [15:0]           beat_cnt_q;
  logic [15:0]           beat_cnt_d;

  logic                  go;
  logic                  addr_bad;
  logic [RAM_ADDR_W-1:0] wrap_mask;
  logic [RAM_ADDR_W-1:0] addr_inc;
  logic [RAM_ADDR_W-1:0] addr_nxt;
  logic [SEL_W-1:0]      ram_be;
  logic [DATA_W-1:0]     ram_rdata;

  assign go = wb_cyc_i & wb_stb_i;

  // Out of range if any bit above the RAM window is set, or the access is not word aligned
  assign addr_bad = ((wb_adr_i >> (RAM_ADDR_W + 2)) != '0) || (wb_adr_i[1:0] != 2'b00);

  // Burst address step: only the masked low bits advance, so wraps stay inside their block
  assign wrap_mask = RAM_ADDR_W'(bte_mask(bte_q));
  assign addr_inc  = addr_q + RAM_ADDR_W'(1);
  assign addr_nxt  = (addr_q & ~wrap_mask) | (addr_inc & wrap_mask);

  // Responses are qualified by the live strobe so a master abort suppresses them at once
  assign wb_ack_o = ack_q & go;
  assign wb_err_o = err_q & go;
  assign wb_dat_o = wb_ack_o ? ram_rdata : '0;

  // Writes happen only on an acked beat, so an aborted or reset beat never reaches the RAM
  assign ram_be = (wb_ack_o && wb_we_i) ? wb_sel_i : '0;

  iob_eth_wb_mem_ram #(
    .ADDR_W (RAM_ADDR_W)
  ) u_ram (
    .clk_i   (clk_i),
    .be_i    (ram_be),
    .addr_i  (addr_q),
    .wdata_i (wb_dat_i),
    .rdata_o (ram_rdata)
  );

  // Bus FSM: accept a cycle, count wait states, then ack beats until the burst ends
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      state_q    <= ST_IDLE;
      ack_q      <= 1'b0;
      err_q      <= 1'b0;
      wait_cnt_q <= '0;
      addr_q     <= '0;
      bte_q      <= '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (go) begin
            addr_q <= wb_adr_i[RAM_ADDR_W+1:2];
            bte_q  <= wb_bte_i;
            if (addr_bad) begin
              // Error skips the wait states and never touches the RAM
              state_q <= ST_ACK;
              err_q   <= 1'b1;
            end else if (WAIT_CYCLES > 0) begin
              state_q    <= ST_WAIT;
              wait_cnt_q <= WAIT_W'(WAIT_CYCLES);
            end else begin
              state_q <= ST_ACK;
              ack_q   <= 1'b1;
            end
          end
        end
        ST_WAIT: begin
          if (!go) begin
            state_q    <= ST_IDLE;
            wait_cnt_q <= '0;
          end else if (wait_cnt_q <= WAIT_W'(1)) begin
            state_q    <= ST_ACK;
            ack_q      <= 1'b1;
            wait_cnt_q <= '0;
          end else begin
            wait_cnt_q <= wait_cnt_q - WAIT_W'(1);
          end
        end
        ST_ACK, ST_BURST: begin
          // Any cycle type other than incrementing closes the cycle after this beat
          if (err_q || !go || (wb_cti_i != CTI_INCR)) begin
            state_q <= ST_IDLE;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
          end else begin
            state_q <= ST_BURST;
          end
          if (ack_q && go) begin
            addr_q <= addr_nxt;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          ack_q   <= 1'b0;
          err_q   <= 1'b0;
        end
      endcase
    end
  end

  // Next beat count: one per ack, pinned at the top value
  always_comb begin
    beat_cnt_d = beat_cnt_q;
    if (wb_ack_o && (beat_cnt_q != 16'hFFFF)) begin
      beat_cnt_d = beat_cnt_q + 16'd1;
    end
  end

  // Beat counter register
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      beat_cnt_q <= '0;
    end else begin
      beat_cnt_q <= beat_cnt_d;
    end
  end

  assign beat_cnt_o = beat_cnt_q;

endmodule

// File: tb/tb_iob_eth_wb_mem.sv
// Bench for the Wishbone slave memory: directed scenarios plus random traffic.
// Expected responses are queued at issue time; a monitor pops them on every ack/err.
// The reference is a flat word array updated with byte-select merges.
module tb_iob_eth_wb_mem;

  localparam int MEM_ADDR_W = 32;
  localparam int RAM_ADDR_W = 12;
  localparam int W          = 1;
  localparam int RAM_WORDS  = 1 << RAM_ADDR_W;
  localparam logic [2:0] CTI_CLS = 3'b000;
  localparam logic [2:0] CTI_INC = 3'b010;
  localparam logic [2:0] CTI_END = 3'b111;

  logic        clk_i    = 1'b0;
  logic        arst_n_i = 1'b1;
  logic [31:0] wb_adr_i;
  logic [3:0]  wb_sel_i;
  logic        wb_we_i;
  logic        wb_cyc_i;
  logic        wb_stb_i;
  logic [31:0] wb_dat_i;
  logic [2:0]  wb_cti_i;
  logic [1:0]  wb_bte_i;
  logic [31:0] wb_dat_o;
  logic        wb_ack_o;
  logic        wb_err_o;
  logic [15:0] beat_cnt_o;

  iob_eth_wb_mem #(
    .MEM_ADDR_W  (MEM_ADDR_W),
    .RAM_ADDR_W  (RAM_ADDR_W),
    .WAIT_CYCLES (W)
  ) dut (
    .clk_i      (clk_i),
    .arst_n_i   (arst_n_i),
    .wb_adr_i   (wb_adr_i),
    .wb_sel_i   (wb_sel_i),
    .wb_we_i    (wb_we_i),
    .wb_cyc_i   (wb_cyc_i),
    .wb_stb_i   (wb_stb_i),
    .wb_dat_i   (wb_dat_i),
    .wb_cti_i   (wb_cti_i),
    .wb_bte_i   (wb_bte_i),
    .wb_dat_o   (wb_dat_o),
    .wb_ack_o   (wb_ack_o),
    .wb_err_o   (wb_err_o),
    .beat_cnt_o (beat_cnt_o)
  );

  typedef struct {
    bit          err;
    bit          rd;
    logic [31:0] dat;
    int unsigned cyc;
    string       tag;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] model_mem [RAM_WORDS];
  int unsigned exp_beats = 0;
  int unsigned cyc_n     = 0;
  int          tests     = 0;
  int          fails     = 0;

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc_n <= cyc_n + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc_n);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] sel);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (sel[b]) r[8*b +: 8] = nw[8*b +: 8];
    return r;
  endfunction

  // Word touched by beat i of a burst: linear rolls over the RAM, wrap-N stays in its block
  function automatic int unsigned burst_word(input int unsigned start, input int bte,
                                             input int unsigned i);
    int unsigned n;
    if (bte == 0) return (start + i) % RAM_WORDS;
    n = 1 << (bte + 1);
    return (start / n) * n + (start + i) % n;
  endfunction

  task automatic idle_bus();
    wb_adr_i = '0; wb_sel_i = '0; wb_we_i = 1'b0; wb_cyc_i = 1'b0;
    wb_stb_i = 1'b0; wb_dat_i = '0; wb_cti_i = CTI_CLS; wb_bte_i = 2'b00;
  endtask

  task automatic do_single(input bit we, input logic [31:0] adr, input logic [3:0] sel,
                           input logic [31:0] dat, input string tag);
    exp_t e;
    bit bad;
    int unsigned wd;
    @(posedge clk_i); #1;
    wb_adr_i = adr; wb_sel_i = sel; wb_we_i = we; wb_dat_i = dat;
    wb_cti_i = CTI_CLS; wb_bte_i = 2'b00; wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
    bad = (adr >= RAM_WORDS * 4) || (adr[1:0] != 2'b00);
    wd = (adr >> 2) % RAM_WORDS;
    e.tag = tag; e.err = bad; e.rd = !we; e.dat = '0;
    if (bad) begin
      e.cyc = cyc_n + 1;
      sb_q.push_back(e);
      repeat (2) @(posedge clk_i);
    end else begin
      e.cyc = cyc_n + 1 + W;
      e.dat = model_mem[wd];
      sb_q.push_back(e);
      if (we) model_mem[wd] = merge(model_mem[wd], dat, sel);
      if (exp_beats < 65535) exp_beats++;
      repeat (W + 2) @(posedge clk_i);
    end
    #1; idle_bus();
  endtask

  task automatic do_burst(input bit we, input int unsigned start, input int bte, input int len,
                          input int rst_beat, input string tag);
    logic [31:0] bd[$];
    exp_t e;
    int unsigned a;
    int unsigned n0;
    for (int i = 0; i < len; i++) bd.push_back($urandom);
    @(posedge clk_i); #1;
    wb_adr_i = start * 4; wb_sel_i = 4'hF; wb_we_i = we; wb_dat_i = bd[0];
    wb_bte_i = 2'(bte); wb_cti_i = (len == 1) ? CTI_END : CTI_INC;
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
    n0 = cyc_n;
    for (int i = 0; i < len; i++) begin
      if (rst_beat >= 0 && i >= rst_beat) break;
      a = burst_word(start, bte, i);
      e.tag = tag; e.err = 1'b0; e.rd = !we; e.cyc = n0 + 1 + W + i; e.dat = model_mem[a];
      sb_q.push_back(e);
      if (we) model_mem[a] = bd[i];
      if (exp_beats < 65535) exp_beats++;
    end
    repeat (W + 1) @(posedge clk_i); #1;
    wb_adr_i = $urandom;
    for (int i = 0; i < len; i++) begin
      if (i == rst_beat) begin
        #1; arst_n_i = 1'b0; #1;
        check({tag, "_rst_ack"}, 32'(wb_ack_o), 32'd0);
        check({tag, "_rst_err"}, 32'(wb_err_o), 32'd0);
        idle_bus();
        repeat (2) @(posedge clk_i); #1;
        check({tag, "_rst_dat"}, wb_dat_o, 32'd0);
        check({tag, "_rst_beats"}, 32'(beat_cnt_o), 32'd0);
        @(posedge clk_i); #1;
        arst_n_i = 1'b1;
        exp_beats = 0;
        break;
      end
      @(posedge clk_i); #1;
      if (i + 1 < len) begin
        wb_dat_i = bd[i+1];
        wb_cti_i = (i + 2 == len) ? CTI_END : CTI_INC;
        wb_adr_i = $urandom;
      end
    end
    idle_bus();
  endtask

  // Start a write, then abandon it during the wait state
  task automatic do_drop(input int unsigned wd, input logic [31:0] dat);
    @(posedge clk_i); #1;
    wb_adr_i = wd * 4; wb_sel_i = 4'hF; wb_we_i = 1'b1; wb_dat_i = dat;
    wb_cti_i = CTI_CLS; wb_bte_i = 2'b00; wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
    @(posedge clk_i); #1;
    wb_cyc_i = 1'b0;
    @(posedge clk_i); #1;
    idle_bus();
    repeat (2) @(posedge clk_i);
  endtask

  // Monitor: every ack/err must match the oldest queued expectation
  initial begin
    exp_t e;
    forever begin
      @(negedge clk_i);
      if (wb_ack_o || wb_err_o) begin
        check("ack_err_exclusive", 32'(wb_ack_o & wb_err_o), 32'd0);
        check("resp_with_cyc", 32'(wb_cyc_i), 32'd1);
        if (sb_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_resp: ack=%0b err=%0b at cycle %0d, expected no response",
                   wb_ack_o, wb_err_o, cyc_n);
        end else begin
          e = sb_q.pop_front();
          check({e.tag, "_kind_err"}, 32'(wb_err_o), 32'(e.err));
          check({e.tag, "_cycle"}, cyc_n, e.cyc);
          if (e.rd && !e.err) check({e.tag, "_data"}, wb_dat_o, e.dat);
        end
      end
    end
  end

  initial begin
    #500000;
    fails++;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned r, wd, st, len, bte;
    logic [31:0] adr;
    idle_bus();
    #2 arst_n_i = 1'b0;
    repeat (3) @(posedge clk_i); #1;
    check("reset_ack", 32'(wb_ack_o), 32'd0);
    check("reset_err", 32'(wb_err_o), 32'd0);
    check("reset_dat", wb_dat_o, 32'd0);
    check("reset_beats", 32'(beat_cnt_o), 32'd0);
    @(posedge clk_i); #1;
    arst_n_i = 1'b1;

    do_single(1'b1, 32'h10, 4'hF, 32'hDEADBEEF, "classic_wr");
    do_single(1'b0, 32'h10, 4'hF, 32'h0, "classic_rd");
    do_single(1'b1, 32'h10, 4'h1, 32'h000000AA, "byte_wr");
    do_single(1'b0, 32'h10, 4'hF, 32'h0, "byte_rd");
    check("beats_after_classic", 32'(beat_cnt_o), exp_beats);

    do_burst(1'b1, 0, 0, 64, -1, "init_burst");
    for (int i = 0; i < 4; i++) do_single(1'b1, 32'h10 + 4 * i, 4'hF, i, "preload");
    do_burst(1'b0, 6, 1, 4, -1, "wrap4_rd");

    do_single(1'b1, 32'h4000, 4'hF, 32'h12345678, "err_range");
    check("beats_after_err", 32'(beat_cnt_o), exp_beats);
    do_single(1'b0, 32'h0, 4'hF, 32'h0, "err_ram_intact");
    do_single(1'b0, 32'h12, 4'hF, 32'h0, "err_misalign");

    do_burst(1'b1, RAM_WORDS - 2, 0, 4, -1, "top_wr");
    do_burst(1'b0, RAM_WORDS - 2, 0, 4, -1, "top_rd");

    do_drop(7, 32'hCAFEF00D);
    do_single(1'b0, 32'h1C, 4'hF, 32'h0, "drop_rd");

    for (int k = 0; k < 150; k++) begin
      r = $urandom_range(0, 9);
      wd = $urandom_range(0, 63);
      if (r <= 3) begin
        do_single(1'($urandom_range(0, 1)), wd * 4, 4'($urandom_range(0, 15)), $urandom, "rnd_single");
      end else if (r <= 7) begin
        bte = $urandom_range(0, 3);
        len = $urandom_range(1, 8);
        st = (bte == 0) ? $urandom_range(0, 64 - len) : wd;
        do_burst(1'($urandom_range(0, 1)), st, bte, len, -1, "rnd_burst");
      end else if (r == 8) begin
        adr = $urandom;
        if ($urandom_range(0, 1) == 1) adr[14] = 1'b1;
        else adr = wd * 4 + $urandom_range(1, 3);
        do_single(1'($urandom_range(0, 1)), adr, 4'hF, $urandom, "rnd_err");
      end else begin
        do_drop(wd, $urandom);
      end
    end
    check("beats_after_random", 32'(beat_cnt_o), exp_beats);

    do_burst(1'b1, 40, 0, 4, 2, "rst_burst");
    for (int i = 0; i < 4; i++) do_single(1'b0, 32'd160 + 4 * i, 4'hF, 32'h0, "rst_readback");
    check("beats_after_reset", 32'(beat_cnt_o), exp_beats);

    repeat (5) @(posedge clk_i);
    check("sb_drain", 32'(sb_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
